cs_seq_ctrl: RTL and testbench

Frame sequencer for the CS computational-system datapath. The datapath shifts one sample per clock and has no stall input, so this block buffers incoming 8-bit samples in a small FIFO and releases a frame only when it can stream it without gaps. It clears the datapath window between frames, suppresses warm-up results, and registers the 10-bit result Y with valid and last qualifiers. It sits between the sample source and the CS instance and drives that instance's `X` and `reset` pins.

---
 rtl/cs_pkg.sv | 17 +
 rtl/cs_sample_fifo.sv | 67 ++++++
 rtl/cs_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_cs_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared types and widths for the CS frame sequencer.
// Contents: sequencer state enum, CS window length, sample (X) and result (Y) widths.
// No logic; imported by cs_sample_fifo and cs_seq_ctrl.
package cs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int CS_WIN = 9;   // CS tap count
  localparam int CS_XW  = 8;   // sample width
  localparam int CS_YW  = 10;  // result width
  localparam int CS_EW  = CS_XW + 1;  // FIFO entry: {last, data}

endpackage

// File: rtl/cs_sample_fifo.sv
// Sample FIFO: DEPTH x {last, data}, with a running count of entries whose last bit is set.
// Latency: a pushed entry is visible on pop_data the cycle after the push; pop_data is combinational.
// Backpressure: a push is dropped when full unless a pop happens in the same cycle.
// Ports: clk, reset (async, active-low), push/push_data, pop/pop_data, full, empty, last_cnt.
module cs_sample_fifo
  import cs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = CS_EW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   last_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;
  logic          push_last;
  logic          pop_last;

  // Pointers carry one extra bit so full and empty are distinguishable;
  // their difference is the fill level and wraps naturally.
  assign level    = wptr - rptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wptr == rptr);
  assign pop_data = mem[rptr[AW-1:0]];

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_last = do_push && push_data[DW-1];
  assign pop_last  = do_pop && pop_data[DW-1];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      last_cnt <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({push_last, pop_last})
        2'b10:   last_cnt <= last_cnt + 1'b1;
        2'b01:   last_cnt <= last_cnt - 1'b1;
        default: last_cnt <= last_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cs_seq_ctrl.sv
// Frame sequencer: buffers samples, streams whole frames gap-free into the CS datapath, registers Y.
// Latency: result for a sample popped in cycle t is on out_data/out_valid in cycle t+2.
// Backpressure: in_ready = FIFO not full; the result side has none (out_valid is a strobe).
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_data/in_last from the source;
//   cs_x/cs_reset to the CS instance, cs_y from it; out_valid/out_data/out_last, busy, err_underrun.
// Build option: define CS_SEQ_WARMUP_EN to suppress the first WIN-1 results of each frame.
module cs_seq_ctrl
  import cs_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WIN        = CS_WIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CS_XW-1:0] in_data,
  input  logic             in_last,
  output logic [CS_XW-1:0] cs_x,
  output logic             cs_reset,
  input  logic [CS_YW-1:0] cs_y,
  output logic             out_valid,
  output logic [CS_YW-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_underrun
);

  localparam int CW = $clog2(WIN + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef CS_SEQ_WARMUP_EN
  localparam bit WARMUP = 1'b1;
`else
  localparam bit WARMUP = 1'b0;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             full;
  logic             empty;
  logic [LW-1:0]    last_cnt;
  logic [CS_EW-1:0] pop_data;
  logic             pop;
  logic             underrun;
  logic             launch;
  logic [CW-1:0]    cnt;
  logic             tag_vld;
  logic             tag_last;
  logic             tag_done;
  logic             emit;

  // in_ready is held low while reset is asserted, independent of the FIFO.
  assign in_ready = reset && !full;

  cs_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (CS_EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_last, in_data}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .last_cnt  (last_cnt)
  );

  // A frame is launched only when it can be streamed without a gap: its end
  // is already buffered, or the FIFO is full and the source must keep up.
  assign launch = (last_cnt != '0) || full;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cs_reset  = 1'b1;
    cs_x      = '0;
    pop       = 1'b0;
    underrun  = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = RUN;
      end
      RUN: begin
        cs_reset = 1'b0;
        if (!empty) begin
          pop  = 1'b1;
          cs_x = pop_data[CS_XW-1:0];
          if (pop_data[CS_XW]) state_nxt = IDLE;
        end else begin
          // Source fell behind mid-frame: abandon the frame; the next one
          // starts from a cleared window.
          underrun  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Without warm-up suppression every tagged pop produces a result.
  assign emit = tag_vld && (tag_done || !WARMUP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tag_vld      <= 1'b0;
      tag_last     <= 1'b0;
      tag_done     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == CLEAR) begin
        cnt <= '0;
      end else if (pop && (cnt != CW'(WIN))) begin
        cnt <= cnt + 1'b1;
      end

      // Tag travels alongside the sample so it lines up with cs_y one cycle
      // later. cnt counts earlier pops, so cnt >= WIN-1 means this pop
      // completes a full window.
      tag_vld  <= pop;
      tag_last <= pop && pop_data[CS_XW];
      tag_done <= pop && (cnt >= CW'(WIN - 1));

      out_valid <= emit;
      out_last  <= emit && tag_last;
      if (emit) out_data <= cs_y;

      if (underrun) err_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cs_seq_ctrl.sv
module tb_cs_seq_ctrl;

`ifdef CS_SEQ_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] cs_x;
  logic       cs_reset;
  logic [9:0] cs_y;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err_underrun;

  cs_seq_ctrl #(.FIFO_DEPTH(16), .WIN(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .cs_x         (cs_x),
    .cs_reset     (cs_reset),
    .cs_y         (cs_y),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference CS: 9-tap shift window, synchronous active-high clear.
  // Y = (sum + appro*9) >> 3, appro = largest window value not above floor(sum/9).
  function automatic logic [9:0] cs_calc(input logic [7:0] w [9]);
    int sum, avg, ap;
    sum = 0;
    for (int i = 0; i < 9; i++) sum += int'(w[i]);
    avg = sum / 9;
    ap  = 0;
    for (int i = 0; i < 9; i++)
      if (int'(w[i]) <= avg && int'(w[i]) > ap) ap = int'(w[i]);
    return 10'((sum + ap * 9) >> 3);
  endfunction

  logic [7:0] win [9] = '{default: 8'd0};
  always @(posedge clk) begin
    if (cs_reset) begin
      for (int i = 0; i < 9; i++) win[i] <= 8'd0;
    end else begin
      win[0] <= cs_x;
      for (int i = 1; i < 9; i++) win[i] <= win[i-1];
    end
  end
  always_comb cs_y = cs_calc(win);

  // Observed results and expected results.
  int gy[$], gl[$], gc[$];
  int ey[$], el[$], ej[$];
  int clr_cnt = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      gy.push_back(int'(out_data));
      gl.push_back(int'(out_last));
      gc.push_back(cyc);
    end
    if (busy && cs_reset) clr_cnt++;
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int smp(input int base, input int step, input int j);
    return (base + step * (j - 1)) & 255;
  endfunction

  // Expected results of one frame, starting from a cleared window.
  function automatic void model_frame(input int len, input int base, input int step,
                                      input bit with_last);
    logic [7:0] w [9];
    for (int i = 0; i < 9; i++) w[i] = 8'd0;
    for (int j = 1; j <= len; j++) begin
      for (int i = 8; i > 0; i--) w[i] = w[i-1];
      w[0] = 8'(smp(base, step, j));
      if (!WARM || j >= 9) begin
        ey.push_back(int'(cs_calc(w)));
        el.push_back((with_last && j == len) ? 1 : 0);
        ej.push_back(j);
      end
    end
  endfunction

  task automatic clear_q();
    gy.delete(); gl.delete(); gc.delete();
    ey.delete(); el.delete(); ej.delete();
  endtask

  // Push a frame at full rate; e_last = cycle stamp of the edge that took the final sample.
  task automatic push_frame(input int len, input int base, input int step,
                            input bit with_last, output int e_last);
    int guard;
    e_last = 0;
    for (int j = 1; j <= len; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(smp(base, step, j));
      in_last  = with_last && (j == len);
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) check("in_ready timeout", 0, 1);
      @(posedge clk); #1;
      e_last = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'd0;
  endtask

  // Result j (1-based pop index) is expected after edge e0+3+j.
  task automatic check_results(input string name, input int e0, input bit timing);
    check($sformatf("%s count", name), gy.size(), ey.size());
    for (int i = 0; i < ey.size() && i < gy.size(); i++) begin
      check($sformatf("%s y[%0d]", name, i), gy[i], ey[i]);
      check($sformatf("%s last[%0d]", name, i), gl[i], el[i]);
      if (timing) check($sformatf("%s cyc[%0d]", name, i), gc[i], e0 + 3 + ej[i]);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " out_valid"}, int'(out_valid), 0);
    check({name, " out_data"}, int'(out_data), 0);
    check({name, " out_last"}, int'(out_last), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " err_underrun"}, int'(err_underrun), 0);
    check({name, " in_ready"}, int'(in_ready), 0);
    check({name, " cs_reset"}, int'(cs_reset), 1);
    check({name, " cs_x"}, int'(cs_x), 0);
  endtask

  typedef struct {
    int len;
    int base;
    int step;
    int last_y;   // hand-computed Y of the frame's final sample
    int cnt_on;   // results with warm-up suppression
    int cnt_off;  // results without
  } vec_t;

  vec_t vecs[5];

  initial begin
    int e0, e1, na, exp_cnt;

    // 1..9: sum 45, appro 5, (45+45)>>3 = 11
    vecs[0] = '{len: 9,  base: 1,   step: 1,  last_y: 11,  cnt_on: 1, cnt_off: 9};
    // 10 x 8: (72+72)>>3 = 18
    vecs[1] = '{len: 10, base: 8,   step: 0,  last_y: 18,  cnt_on: 2, cnt_off: 10};
    // 3,5,7,9 + five zeros: sum 24, avg 2, appro 0 -> 3
    vecs[2] = '{len: 4,  base: 3,   step: 2,  last_y: 3,   cnt_on: 0, cnt_off: 4};
    // 40..120 window: (720+720)>>3 = 180
    vecs[3] = '{len: 12, base: 10,  step: 10, last_y: 180, cnt_on: 4, cnt_off: 12};
    // 100..204 step 13: sum 1368, appro 152 -> 342
    vecs[4] = '{len: 9,  base: 100, step: 13, last_y: 342, cnt_on: 1, cnt_off: 9};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle in_ready", int'(in_ready), 1);

    for (int v = 0; v < 5; v++) begin
      clear_q();
      model_frame(vecs[v].len, vecs[v].base, vecs[v].step, 1'b1);
      push_frame(vecs[v].len, vecs[v].base, vecs[v].step, 1'b1, e0);
      repeat (vecs[v].len + 20) @(posedge clk);
      #1;
      check_results($sformatf("vec%0d", v), e0, 1'b1);
      exp_cnt = WARM ? vecs[v].cnt_on : vecs[v].cnt_off;
      check($sformatf("vec%0d hand count", v), gy.size(), exp_cnt);
      if (gy.size() > 0) begin
        check($sformatf("vec%0d hand last_y", v), gy[gy.size()-1], vecs[v].last_y);
        check($sformatf("vec%0d hand last flag", v), gl[gl.size()-1], 1);
      end
      check($sformatf("vec%0d busy after", v), int'(busy), 0);
    end

    // Back-to-back frames: one CLEAR each, fresh window for the second.
    clear_q();
    clr_cnt = 0;
    model_frame(9, 1, 1, 1'b1);
    model_frame(9, 50, 5, 1'b1);
    push_frame(9, 1, 1, 1'b1, e0);
    push_frame(9, 50, 5, 1'b1, e1);
    repeat (50) @(posedge clk);
    #1;
    check_results("b2b", e0, 1'b0);
    check("b2b clear cycles", clr_cnt, 2);
    na = WARM ? 1 : 9;
    if (gy.size() > na) check("b2b gap", gc[na] - gc[na-1], WARM ? 11 : 3);
    if (gy.size() > 0) check("b2b second last_y", gy[gy.size()-1], 157);

    // Launch on full, then starve the datapath.
    check("underrun pre", int'(err_underrun), 0);
    clear_q();
    model_frame(16, 20, 3, 1'b0);
    push_frame(16, 20, 3, 1'b0, e0);
    #1;
    check("full in_ready", int'(in_ready), 0);
    repeat (40) @(posedge clk);
    #1;
    check_results("underrun", e0, 1'b1);
    check("underrun flag", int'(err_underrun), 1);
    check("underrun busy", int'(busy), 0);
    clear_q();
    model_frame(9, 1, 1, 1'b1);
    push_frame(9, 1, 1, 1'b1, e0);
    repeat (30) @(posedge clk);
    #1;
    check_results("post-underrun", e0, 1'b1);
    if (gy.size() > 0) check("post-underrun last_y", gy[gy.size()-1], 11);
    check("underrun sticky", int'(err_underrun), 1);

    // Asynchronous reset in the middle of RUN.
    clear_q();
    push_frame(12, 1, 1, 1'b1, e0);
    repeat (5) @(posedge clk);
    #3;
    check("pre-reset busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check_reset_values("mid-run reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    // 5..45 step 5: sum 225, appro 25 -> (225+225)>>3 = 56
    model_frame(9, 5, 5, 1'b1);
    push_frame(9, 5, 5, 1'b1, e0);
    repeat (30) @(posedge clk);
    #1;
    check_results("post-reset", e0, 1'b1);
    if (gy.size() > 0) check("post-reset last_y", gy[gy.size()-1], 56);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
